// File: rtl/crc_engine_if.sv
// Handshake bundle for crc_engine: word input stream and registered CRC result.
interface crc_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_ok;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, crc_out, crc_ok
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, crc_out, crc_ok
  );
endinterface

// File: rtl/crc_engine.sv
// Streaming CRC generator/checker: BPC bits per clock, MSB-first from the word buffer,
// framed words in over valid/ready, final CRC and residue check out over valid/ready.
module crc_engine #(
  parameter int unsigned      CRC_W       = 8,
  parameter logic [CRC_W-1:0] POLY        = 'h07,
  parameter logic [CRC_W-1:0] INIT        = 'h00,
  parameter logic [CRC_W-1:0] XOR_OUT     = 'h00,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE     = 'h00,
  parameter int unsigned      DATA_W      = 8,
  parameter int unsigned      BPC         = 8
) (
  input logic         clk,
  input logic         reset_n,
  crc_engine_if.slave bus
);

  if (CRC_W < 3 || CRC_W > 32) begin : g_bad_crc_w
    $error("crc_engine: CRC_W must be in 3..32");
  end
  if (BPC < 1 || BPC > DATA_W) begin : g_bad_bpc_range
    $error("crc_engine: BPC must be in 1..DATA_W");
  end else if (DATA_W % BPC != 0) begin : g_bad_bpc_div
    $error("crc_engine: DATA_W must be a multiple of BPC");
  end

  localparam int unsigned STEPS = DATA_W / BPC;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CRC_W-1:0]  crc_q;
  logic [DATA_W-1:0] buf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;
  logic              out_valid_q;
  logic [CRC_W-1:0]  crc_out_q;
  logic              crc_ok_q;

  logic [CRC_W-1:0]  crc_d;
  logic [CRC_W-1:0]  crc_out_d;
  logic [DATA_W-1:0] word_d;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                input logic [BPC-1:0]   bits);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int unsigned i = 0; i < BPC; i++) begin
      fb = c[CRC_W-1] ^ bits[BPC-1-i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int unsigned i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int unsigned i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  always_comb begin
    crc_d     = crc_step(crc_q, buf_q[DATA_W-1 -: BPC]);
    crc_out_d = (REFLECT_OUT ? rev_crc(crc_d) : crc_d) ^ XOR_OUT;
    word_d    = REFLECT_IN ? rev_data(bus.in_data) : bus.in_data;
  end

  // Result registers are loaded from the final step's combinational value so they
  // are valid in the same cycle the FSM enters DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      crc_q       <= INIT;
      buf_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      crc_out_q   <= '0;
      crc_ok_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            buf_q   <= word_d;
            last_q  <= bus.in_last;
            cnt_q   <= CNT_W'(STEPS);
            state_q <= S_SHIFT;
            if (bus.in_first) crc_q <= INIT;
          end
        end
        S_SHIFT: begin
          crc_q <= crc_d;
          buf_q <= buf_q << BPC;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (last_q) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              crc_out_q   <= crc_out_d;
              crc_ok_q    <= (crc_d == RESIDUE);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            crc_q       <= INIT;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_crc_engine.sv
// Table-driven bench for crc_engine across four configurations (CRC-8 BPC=8/1,
// CRC-16/CCITT-FALSE BPC=4, CRC-32 reflected) plus hand-written stall/abort sequences.
module tb_crc_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned sel = 0;
  logic        valid = 1'b0, first = 1'b0, last = 1'b0, oready = 1'b0;
  logic [7:0]  data = '0;
  logic        rdy, ovalid, okv;
  logic [31:0] crc;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  crc_engine_if #(.DATA_W(8), .CRC_W(8))  if0 ();
  crc_engine_if #(.DATA_W(8), .CRC_W(8))  if1 ();
  crc_engine_if #(.DATA_W(8), .CRC_W(16)) if2 ();
  crc_engine_if #(.DATA_W(8), .CRC_W(32)) if3 ();

  assign if0.in_valid = valid && (sel == 0);
  assign if0.in_data = data;  assign if0.in_first = first;  assign if0.in_last = last;
  assign if0.out_ready = oready && (sel == 0);
  assign if1.in_valid = valid && (sel == 1);
  assign if1.in_data = data;  assign if1.in_first = first;  assign if1.in_last = last;
  assign if1.out_ready = oready && (sel == 1);
  assign if2.in_valid = valid && (sel == 2);
  assign if2.in_data = data;  assign if2.in_first = first;  assign if2.in_last = last;
  assign if2.out_ready = oready && (sel == 2);
  assign if3.in_valid = valid && (sel == 3);
  assign if3.in_data = data;  assign if3.in_first = first;  assign if3.in_last = last;
  assign if3.out_ready = oready && (sel == 3);

  crc_engine u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  crc_engine #(.BPC(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  crc_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .BPC(4))
    u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
               .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1))
    u3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  always_comb begin
    rdy = 1'b0; ovalid = 1'b0; okv = 1'b0; crc = '0;
    case (sel)
      0: begin rdy = if0.in_ready; ovalid = if0.out_valid; okv = if0.crc_ok; crc = 32'(if0.crc_out); end
      1: begin rdy = if1.in_ready; ovalid = if1.out_valid; okv = if1.crc_ok; crc = 32'(if1.crc_out); end
      2: begin rdy = if2.in_ready; ovalid = if2.out_valid; okv = if2.crc_ok; crc = 32'(if2.crc_out); end
      3: begin rdy = if3.in_ready; ovalid = if3.out_valid; okv = if3.crc_ok; crc = 32'(if3.crc_out); end
      default: ;
    endcase
  end

  typedef struct {
    int unsigned dut;
    int unsigned len;
    logic [95:0] data;
    logic [31:0] crc;
    logic        ok;
  } vec_t;

  localparam int NV = 14;
  vec_t        tv [NV];
  int unsigned lat_n [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic f, input logic l);
    int unsigned n = 0;
    @(negedge clk);
    while (rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (rdy !== 1'b1) begin
      check("in_ready timeout", 32'(rdy), 32'd1);
      return;
    end
    valid = 1'b1; data = d; first = f; last = l;
    @(negedge clk);
    valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic wait_result(output int unsigned lat, output bit got);
    lat = 0;
    while (ovalid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    got = (ovalid === 1'b1);
    if (!got) check("out_valid timeout", 32'(ovalid), 32'd1);
  endtask

  task automatic ack(input logic [31:0] exp_crc);
    oready = 1'b1;
    @(negedge clk);
    oready = 1'b0;
    check("out_valid after ack", 32'(ovalid), 32'd0);
    check("crc_out kept after ack", crc, exp_crc);
    check("in_ready after ack", 32'(rdy), 32'd1);
  endtask

  task automatic send_str(input logic [71:0] s);
    logic [71:0] v;
    v = s;
    for (int w = 0; w < 9; w++) push(v[71-8*w -: 8], w == 0, w == 8);
  endtask

  initial begin
    int unsigned lat;
    bit          got;
    logic [95:0] vd;

    lat_n = '{1, 8, 2, 1};
    tv[0]  = '{0, 9,  96'h313233343536373839000000, 32'hF4,       1'b0};
    tv[1]  = '{0, 1,  96'h010000000000000000000000, 32'h07,       1'b0};
    tv[2]  = '{0, 1,  96'h000000000000000000000000, 32'h00,       1'b1};
    tv[3]  = '{0, 1,  96'hFF0000000000000000000000, 32'hF3,       1'b0};
    tv[4]  = '{0, 1,  96'h800000000000000000000000, 32'h89,       1'b0};
    tv[5]  = '{0, 10, 96'h313233343536373839F40000, 32'h00,       1'b1};
    tv[6]  = '{0, 10, 96'h313233343536373839F50000, 32'h07,       1'b0};
    tv[7]  = '{1, 9,  96'h313233343536373839000000, 32'hF4,       1'b0};
    tv[8]  = '{1, 1,  96'h010000000000000000000000, 32'h07,       1'b0};
    tv[9]  = '{2, 9,  96'h313233343536373839000000, 32'h29B1,     1'b0};
    tv[10] = '{2, 11, 96'h31323334353637383929B100, 32'h0000,     1'b1};
    tv[11] = '{2, 11, 96'h31323334353637383929B000, 32'h1021,     1'b0};
    tv[12] = '{3, 9,  96'h313233343536373839000000, 32'hCBF43926, 1'b0};
    tv[13] = '{3, 1,  96'h000000000000000000000000, 32'hD202EF8D, 1'b0};

    // Reset values on every configuration
    repeat (3) @(negedge clk);
    for (int unsigned s = 0; s < 4; s++) begin
      sel = s; #1;
      check("reset out_valid", 32'(ovalid), 32'd0);
      check("reset crc_out", crc, 32'd0);
      check("reset crc_ok", 32'(okv), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int unsigned s = 0; s < 4; s++) begin
      sel = s; #1;
      check("in_ready after reset", 32'(rdy), 32'd1);
    end

    for (int v = 0; v < NV; v++) begin
      sel = tv[v].dut;
      vd  = tv[v].data;
      for (int w = 0; w < int'(tv[v].len); w++)
        push(vd[95-8*w -: 8], w == 0, w == int'(tv[v].len) - 1);
      check("in_ready low in SHIFT", 32'(rdy), 32'd0);
      wait_result(lat, got);
      if (got) begin
        check($sformatf("vec%0d crc_out", v), crc, tv[v].crc);
        check($sformatf("vec%0d crc_ok", v), 32'(okv), 32'(tv[v].ok));
        check($sformatf("vec%0d latency", v), lat, lat_n[tv[v].dut]);
        ack(tv[v].crc);
      end
    end

    // Stall 10 cycles in DONE with in_valid asserted; result must not move
    sel = 0;
    push(8'h01, 1'b1, 1'b1);
    wait_result(lat, got);
    valid = 1'b1; data = 8'hFF; first = 1'b1; last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall crc_out", crc, 32'h07);
      check("stall out_valid", 32'(ovalid), 32'd1);
    end
    check("in_ready low in DONE", 32'(rdy), 32'd0);
    valid = 1'b0; first = 1'b0; last = 1'b0;
    ack(32'h07);

    // in_valid during SHIFT is ignored (BPC=1 gives a long SHIFT phase)
    sel = 1;
    push(8'h01, 1'b1, 1'b1);
    valid = 1'b1; data = 8'hFF; first = 1'b1; last = 1'b1;
    repeat (4) @(negedge clk);
    check("in_ready low mid-SHIFT", 32'(rdy), 32'd0);
    valid = 1'b0; first = 1'b0; last = 1'b0;
    wait_result(lat, got);
    if (got) begin
      check("SHIFT-ignore crc_out", crc, 32'h07);
      check("SHIFT-ignore remaining cycles", lat, 32'd4);
      ack(32'h07);
    end

    // Mid-frame in_first restarts the running register
    sel = 0;
    push(8'h31, 1'b1, 1'b0);
    push(8'h32, 1'b0, 1'b0);
    push(8'h01, 1'b1, 1'b1);
    wait_result(lat, got);
    if (got) begin
      check("restart crc_out", crc, 32'h07);
      ack(32'h07);
    end

    // Reset mid-SHIFT aborts the frame; next frame is clean
    sel = 1;
    push(8'h31, 1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort out_valid", 32'(ovalid), 32'd0);
    check("abort crc_out", crc, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort no result", 32'(ovalid), 32'd0);
    check("abort in_ready", 32'(rdy), 32'd1);
    send_str(72'h313233343536373839);
    wait_result(lat, got);
    if (got) begin
      check("post-abort crc_out", crc, 32'hF4);
      ack(32'hF4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
